pico_mem: RTL and testbench

Single-port program/data memory for the PicoComputer core: the responder end of the CPU memory interface (`mem_we`/`mem_addr`/`mem_data` in, `mem_in` out). After reset it first accepts a program image over a valid/ready boot-load stream, writing consecutive words from address 0. It then releases the CPU through `cpu_run` and serves CPU reads and writes with one-cycle read latency.

---
 rtl/pico_mem.sv | 110 +++++++++++
 tb/tb_pico_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pico_mem.sv
// Single-port program/data memory: boot-loads an image over a valid/ready stream, then serves CPU reads and writes.
// Latency: read data registered, 1 cycle after the address; writes land at the edge; one boot word per cycle.
// Backpressure: load_ready is high only in LOAD outside reset; RUN never stalls the CPU.
// Optional: define PICO_MEM_WRITE_FWD_EN to forward same-cycle write data to the read port.
module pico_mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = 1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] load_ptr;
    logic                  accept;
    logic                  cpu_wr;

    // Next-state and handshake decode; reset cycles never accept or write.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cpu_run    = 1'b0;
        accept     = 1'b0;
        cpu_wr     = 1'b0;
        case (state)
            LOAD: begin
                load_ready = !rst;
                accept     = load_valid && !rst;
                // Leave on the marked last word, or when the top address is filled (no wrap).
                if (accept && (load_last || load_ptr == {ADDR_WIDTH{1'b1}})) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cpu_run = 1'b1;
                cpu_wr  = mem_we && !rst;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Load pointer and word counter; the counter holds its final value through RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_ptr   <= '0;
            load_count <= '0;
        end else if (accept) begin
            load_ptr   <= load_ptr + PTR_ONE;
            load_count <= load_count + COUNT_ONE;
        end
    end

    // Storage array; deliberately not reset so an image survives a CPU reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[load_ptr] <= load_data;
        end else if (cpu_wr) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Registered read port; held at zero outside RUN.
    always_ff @(posedge clk) begin
        if (rst || state != RUN) begin
            mem_in <= '0;
        end else begin
`ifdef PICO_MEM_WRITE_FWD_EN
            // Read and write share one address, so a write always hits the read.
            if (mem_we) begin
                mem_in <= mem_data;
            end else begin
                mem_in <= mem[mem_addr];
            end
`else
            mem_in <= mem[mem_addr];
`endif
        end
    end

endmodule

// File: tb/tb_pico_mem.sv
// Bench for pico_mem: directed boot/run scenarios plus randomized traffic against a behavioural model.
// Latency: model advances once per rising edge; outputs compared on the falling edge.
// Backpressure: load gaps and ignored load_valid in RUN are exercised.
module tb_pico_mem;

    localparam int AW = 6;
    localparam int DW = 16;
`ifdef PICO_MEM_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_in;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          cpu_run;
    logic [AW:0]   load_count;

    always #5 clk = ~clk;

    pico_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_in     (mem_in),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_run    (cpu_run),
        .load_count (load_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit            started = 1'b0;
    bit            m_run;
    int            m_count;
    logic [DW-1:0] m_in;
    bit            m_in_known;
    logic [DW-1:0] mm [64];
    bit            mk [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Apply one clock edge's worth of the memory's rules to the model.
    task automatic model_edge();
        logic [DW-1:0] rd;
        bit            rk;
        if (rst) begin
            m_run      = 1'b0;
            m_count    = 0;
            m_in       = '0;
            m_in_known = 1'b1;
        end else if (!m_run) begin
            m_in       = '0;
            m_in_known = 1'b1;
            if (load_valid) begin
                mm[m_count] = load_data;
                mk[m_count] = 1'b1;
                if (load_last || m_count == 63) m_run = 1'b1;
                m_count++;
            end
        end else begin
            rd = mm[mem_addr];
            rk = mk[mem_addr];
            if (mem_we && FWD) begin
                m_in       = mem_data;
                m_in_known = 1'b1;
            end else begin
                m_in       = rd;
                m_in_known = rk;
            end
            if (mem_we) begin
                mm[mem_addr] = mem_data;
                mk[mem_addr] = 1'b1;
            end
        end
    endtask

    // Advance one cycle; inputs change only just after the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        started = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic rd_addr(input logic [AW-1:0] a);
        mem_we   = 1'b0;
        mem_addr = a;
        step();
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("load_ready", 32'(load_ready), 32'(!m_run && !rst));
            check("cpu_run", 32'(cpu_run), 32'(m_run));
            check("load_count", 32'(load_count), 32'(m_count));
            if (m_in_known) check("mem_in", 32'(mem_in), 32'(m_in));
        end
    end

    logic [DW-1:0] first_word;

    initial begin
        for (int i = 0; i < 64; i++) mk[i] = 1'b0;
        rst        = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        step();
        step();
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_mem_in", 32'(mem_in), 32'd0);
        rst = 1'b0;
        step();
        check("idle_load_ready", 32'(load_ready), 32'd1);

        // Boot load of three words
        load_word(16'h1111, 1'b0);
        check("boot_ready_1", 32'(load_ready), 32'd1);
        load_word(16'h2222, 1'b0);
        check("boot_run_early", 32'(cpu_run), 32'd0);
        load_word(16'h3333, 1'b1);
        check("boot_cpu_run", 32'(cpu_run), 32'd1);
        check("boot_ready_low", 32'(load_ready), 32'd0);
        check("boot_count", 32'(load_count), 32'd3);
        rd_addr(6'd0); check("boot_rd0", 32'(mem_in), 32'h1111);
        rd_addr(6'd1); check("boot_rd1", 32'(mem_in), 32'h2222);
        rd_addr(6'd2); check("boot_rd2", 32'(mem_in), 32'h3333);

        // CPU write then read
        mem_we = 1'b1; mem_addr = 6'h05; mem_data = 16'hBEEF;
        step();
        rd_addr(6'h05); check("cpu_wr_rd", 32'(mem_in), 32'hBEEF);

        // Read-during-write to the same address
        mem_we = 1'b1; mem_addr = 6'h07; mem_data = 16'h00AA;
        step();
        mem_data = 16'h0055;
        step();
        check("rdw", 32'(mem_in), FWD ? 32'h0055 : 32'h00AA);
        rd_addr(6'h07); check("rdw_after", 32'(mem_in), 32'h0055);

        // Mid-run reset, reload one word while the CPU tries to write
        rst = 1'b1;
        step();
        check("midrst_cpu_run", 32'(cpu_run), 32'd0);
        check("midrst_count", 32'(load_count), 32'd0);
        rst = 1'b0;
        mem_we = 1'b1; mem_addr = 6'h05; mem_data = 16'hDEAD;
        load_word(16'h4444, 1'b1);
        mem_we = 1'b0;
        check("reload_count", 32'(load_count), 32'd1);
        rd_addr(6'd0); check("reload_rd0", 32'(mem_in), 32'h4444);
        rd_addr(6'd1); check("reload_rd1", 32'(mem_in), 32'h2222);
        rd_addr(6'h05); check("load_we_ignored", 32'(mem_in), 32'hBEEF);

        // Load with two-cycle gaps between words
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < 2; g++) begin
                load_data = DW'($urandom);
                load_last = 1'($urandom);
                step();
            end
            load_last = 1'b0;
            load_word(DW'($urandom), i == 4);
        end
        check("gap_count", 32'(load_count), 32'd5);
        for (int a = 0; a < 6; a++) rd_addr(AW'(a));

        // Full-array load without a last marker
        rst = 1'b1; step(); rst = 1'b0;
        first_word = DW'($urandom);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            load_word(i == 0 ? first_word : DW'($urandom), 1'b0);
        end
        check("full_count", 32'(load_count), 32'd64);
        check("full_cpu_run", 32'(cpu_run), 32'd1);
        check("full_ready", 32'(load_ready), 32'd0);
        load_word(~first_word, 1'b0);
        rd_addr(6'd0); check("full_addr0", 32'(mem_in), 32'(first_word));

        // Randomized CPU traffic with stray load activity
        for (int c = 0; c < 400; c++) begin
            mem_we     = 1'($urandom);
            mem_addr   = AW'($urandom);
            mem_data   = DW'($urandom);
            load_valid = 1'($urandom);
            load_data  = DW'($urandom);
            step();
        end
        load_valid = 1'b0;
        mem_we     = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
